nmcu_instr_dispatcher: RTL

//  Front-end stage of the NMCU. Accepts instruction_t words from the CPU chiplet link and buffers

---
 rtl/instr_pkg.sv | 43 ++++
 rtl/nmcu_pkg.sv | 9 +
 rtl/nmcu_instr_fifo.sv | 60 ++++++
 rtl/nmcu_instr_dispatcher.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Instruction/response formats, opcodes, status codes and dispatcher FSM states.
package instr_pkg;

    import nmcu_pkg::*;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h1;
    localparam logic [3:0] OP_STORE  = 4'h2;
    localparam logic [3:0] OP_MATMUL = 4'h3;
    localparam logic [3:0] OP_HALT   = 4'h4;

    localparam logic [1:0] RESP_OK   = 2'd0;
    localparam logic [1:0] RESP_ERR  = 2'd1;
    localparam logic [1:0] RESP_BUSY = 2'd2;

    typedef struct packed {
        logic [3:0]            opcode;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic [DIM_WIDTH-1:0]  mat_n;
        logic [DIM_WIDTH-1:0]  mat_m;
        logic [DIM_WIDTH-1:0]  mat_k;
    } instruction_t;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            status;
        logic [DATA_WIDTH-1:0] data;
    } nmcu_cpu_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_HALTED
    } dispatch_state_t;

    function automatic logic matmul_dims_ok(input instruction_t instr);
        return (instr.mat_n != '0) && (instr.mat_m != '0) && (instr.mat_k != '0);
    endfunction

endpackage

// File: rtl/nmcu_pkg.sv
// Shared NMCU width constants used by the dispatcher and its datapath interfaces.
package nmcu_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int LEN_WIDTH  = 16;
    localparam int DATA_WIDTH = 32;
    localparam int DIM_WIDTH  = 8;

endpackage

// File: rtl/nmcu_instr_fifo.sv
// In-order synchronous instruction FIFO; DEPTH must be a power of two so the
// pointers wrap for free.
module nmcu_instr_fifo
    import instr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  instruction_t wr_data,
    input  logic         pop,
    output instruction_t rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    instruction_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once the count covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/nmcu_instr_dispatcher.sv
// NMCU front end: queues CPU instructions, issues them one at a time to the datapath
// and returns one response per executed op. Optional macro: NMCU_DISPATCH_ILLEGAL_CHK_EN.
module nmcu_instr_dispatcher
    import nmcu_pkg::*;
    import instr_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_valid_i,
    output logic                  cpu_ready_o,
    input  instruction_t          cpu_instr_i,
    output nmcu_cpu_resp_t        resp_o,
    input  logic                  resp_ready_i,
    output logic                  exe_valid_o,
    input  logic                  exe_ready_i,
    output instruction_t          exe_instr_o,
    input  logic                  exe_done_i,
    input  logic [DATA_WIDTH-1:0] exe_data_i,
    input  logic                  exe_error_i,
    output logic                  busy_o,
    output logic                  halted_o
);

    dispatch_state_t       state_q;
    dispatch_state_t       state_d;

    instruction_t          fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;

    instruction_t          exe_instr_q;
    logic                  halt_q;
    logic                  resp_load;
    logic [1:0]            resp_status_d;
    logic [DATA_WIDTH-1:0] resp_data_d;
    logic [1:0]            resp_status_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [1:0]            done_status;
    logic [DATA_WIDTH-1:0] done_data;

    // Ready deliberately ignores a same-cycle pop so it stays a simple registered-state decode.
    assign cpu_ready_o = !fifo_full && (state_q != ST_HALTED);
    assign fifo_push   = cpu_valid_i && cpu_ready_o;

    nmcu_instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (cpu_instr_i),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign done_status = exe_error_i ? RESP_ERR : RESP_OK;
    assign done_data   = (exe_instr_q.opcode == OP_STORE) ? '0 : exe_data_i;

    always_comb begin
        state_d       = state_q;
        fifo_pop      = 1'b0;
        resp_load     = 1'b0;
        resp_status_d = RESP_OK;
        resp_data_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    case (fifo_head.opcode)
                        OP_NOP: begin
                            state_d = ST_IDLE;
                        end
                        OP_HALT: begin
                            resp_load = 1'b1;
                            state_d   = ST_RESP;
                        end
                        OP_LOAD, OP_STORE: begin
                            state_d = ST_ISSUE;
                        end
                        OP_MATMUL: begin
`ifdef NMCU_DISPATCH_ILLEGAL_CHK_EN
                            if (matmul_dims_ok(fifo_head)) begin
                                state_d = ST_ISSUE;
                            end else begin
                                resp_load     = 1'b1;
                                resp_status_d = RESP_ERR;
                                state_d       = ST_RESP;
                            end
`else
                            state_d = ST_ISSUE;
`endif
                        end
                        default: begin
`ifdef NMCU_DISPATCH_ILLEGAL_CHK_EN
                            resp_load     = 1'b1;
                            resp_status_d = RESP_ERR;
                            state_d       = ST_RESP;
`else
                            state_d = ST_IDLE;
`endif
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                if (exe_ready_i) begin
                    if (exe_done_i) begin
                        resp_load     = 1'b1;
                        resp_status_d = done_status;
                        resp_data_d   = done_data;
                        state_d       = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (exe_done_i) begin
                    resp_load     = 1'b1;
                    resp_status_d = done_status;
                    resp_data_d   = done_data;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = halt_q ? ST_HALTED : ST_IDLE;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every popped word, even a dropped NOP, lands in the issue register; halt_q
    // remembers whether the op now retiring was HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_instr_q   <= '0;
            halt_q        <= 1'b0;
            resp_status_q <= RESP_OK;
            resp_data_q   <= '0;
        end else begin
            if (fifo_pop) begin
                exe_instr_q <= fifo_head;
                halt_q      <= (fifo_head.opcode == OP_HALT);
            end
            if (resp_load) begin
                resp_status_q <= resp_status_d;
                resp_data_q   <= resp_data_d;
            end
        end
    end

    always_comb begin
        resp_o = '0;
        if (state_q == ST_RESP) begin
            resp_o.valid  = 1'b1;
            resp_o.status = resp_status_q;
            resp_o.data   = resp_data_q;
        end
    end

    assign exe_valid_o = (state_q == ST_ISSUE);
    assign exe_instr_o = exe_instr_q;
    assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;
    assign halted_o    = (state_q == ST_HALTED);

endmodule
